step_gen: RTL

STEP_GEN -- requirements
Module: step_gen

---
 rtl/step_gen_pkg.sv | 11 +
 rtl/step_gen_debouncer.sv | 87 ++++++++
 rtl/step_gen.sv | 50 +++++
 3 files changed

// File: rtl/step_gen_pkg.sv
// rtl/step_gen_pkg.sv - shared debounce state encoding for step_gen
package step_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } db_state_t;

endpackage

// File: rtl/step_gen_debouncer.sv
// rtl/step_gen_debouncer.sv - two-flop synchronizer and debounce FSM with press strobe
module debouncer
    import step_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    db_state_t     state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= CHK_HI;
                        cnt   <= '0;
                    end
                end
                CHK_HI: begin
                    if (!s2) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= HIGH;
                        cnt   <= '0;
                        level <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state <= CHK_LO;
                        cnt   <= '0;
                    end
                end
                CHK_LO: begin
                    if (s2) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

    // Strobe is decoded from registers only, so it lines up with the CHK_HI->HIGH edge.
    assign press = (state == CHK_HI) && s2 && (cnt == CNT_MAX);

endmodule

// File: rtl/step_gen.sv
// rtl/step_gen.sv - step pulse generator: debounced manual press or auto prescaler tick
module step_gen
    import step_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_DIV        = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic mode,
    output logic step,
    output logic btn_level
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic          press;
    logic          tick;
    logic [PW-1:0] presc;

    debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .level(btn_level),
        .press(press)
    );

    assign tick = (presc == PRE_MAX);

    // Prescaler parks at zero in manual mode so every auto entry gets a full period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            step  <= 1'b0;
        end else begin
            if (!mode || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
            step <= mode ? tick : press;
        end
    end

endmodule
